// File: rtl/parking_alloc_ctrl_if.sv
// Button/zone inputs and count/gate/status outputs of the parking allocator.
// The master modport is the driver side (car sensors / bench); the slave
// modport is the allocator itself.
interface parking_alloc_ctrl_if;
    logic       btn_in;
    logic       special;
    logic       btn_out;
    logic [1:0] out_zone;
    logic [2:0] remain_flr_spec_0;
    logic [2:0] remain_flr_norm_0;
    logic [2:0] remain_flr_1;
    logic       gate_in_open;
    logic       gate_out_open;
    logic       full;
    logic       reject;

    modport master (
        output btn_in,
        output special,
        output btn_out,
        output out_zone,
        input  remain_flr_spec_0,
        input  remain_flr_norm_0,
        input  remain_flr_1,
        input  gate_in_open,
        input  gate_out_open,
        input  full,
        input  reject
    );

    modport slave (
        input  btn_in,
        input  special,
        input  btn_out,
        input  out_zone,
        output remain_flr_spec_0,
        output remain_flr_norm_0,
        output remain_flr_1,
        output gate_in_open,
        output gate_out_open,
        output full,
        output reject
    );
endinterface

// File: rtl/parking_alloc_ctrl.sv
// Parking spot allocator: debounced-by-sync entry/exit buttons, three free-spot
// counters (floor-0 special, floor-0 normal, floor-1), and two independent gate
// FSMs that hold their gate open for GATE_CYCLES cycles per accepted car.
// Each capacity must be at most 5 and their sum at most 10.
module parking_alloc_ctrl #(
    parameter int unsigned GATE_CYCLES = 8,
    parameter int unsigned CAP_SPEC_0  = 2,
    parameter int unsigned CAP_NORM_0  = 3,
    parameter int unsigned CAP_FLR_1   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    parking_alloc_ctrl_if.slave  bus
);

    localparam logic [2:0] CapSpec = 3'(CAP_SPEC_0);
    localparam logic [2:0] CapNorm = 3'(CAP_NORM_0);
    localparam logic [2:0] CapFlr  = 3'(CAP_FLR_1);

    localparam int unsigned         GateW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GateW-1:0]    GateLast = GateW'(GATE_CYCLES - 1);
    localparam logic [GateW-1:0]    GateOne  = GateW'(1);

    typedef enum logic {
        StIdle,
        StOpen
    } gate_state_e;

    // Synchronizer, edge-detector and arming flops
    logic in_s1, in_s2, in_s3, in_armed;
    logic out_s1, out_s2, out_s3, out_armed;
    // Two-stage "pipeline valid" marker: the synchronized level is meaningful
    // only once the reset-cleared synchronizer has been refilled.
    logic rdy0, rdy1;

    logic in_ev, out_ev;

    // Count and status registers
    logic [2:0] spec_q, norm_q, flr_q;
    logic [2:0] spec_d, norm_d, flr_d;
    logic       full_q, reject_q;

    // Gate FSM registers
    gate_state_e            in_state_q, out_state_q;
    logic [GateW-1:0]       in_timer_q, out_timer_q;
    logic                   gate_in_q, gate_out_q;

    // Allocation decode
    logic in_go, out_go;
    logic take_spec, take_norm, take_flr, in_refuse;
    logic give_spec, give_norm, give_flr, out_bad;
    logic in_accept, out_accept;

    // Two-flop synchronizers plus edge-detect flop; a button must be seen low
    // after reset before it can raise an event, so a press held across reset
    // release is ignored until it is released and pressed again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_s1     <= 1'b0;
            in_s2     <= 1'b0;
            in_s3     <= 1'b0;
            in_armed  <= 1'b0;
            out_s1    <= 1'b0;
            out_s2    <= 1'b0;
            out_s3    <= 1'b0;
            out_armed <= 1'b0;
            rdy0      <= 1'b0;
            rdy1      <= 1'b0;
        end else begin
            in_s1     <= bus.btn_in;
            in_s2     <= in_s1;
            in_s3     <= in_s2;
            out_s1    <= bus.btn_out;
            out_s2    <= out_s1;
            out_s3    <= out_s2;
            rdy0      <= 1'b1;
            rdy1      <= rdy0;
            in_armed  <= in_armed | (rdy1 & ~in_s2);
            out_armed <= out_armed | (rdy1 & ~out_s2);
        end
    end

    assign in_ev  = in_s2 & ~in_s3 & in_armed;
    assign out_ev = out_s2 & ~out_s3 & out_armed;

    // Zone selection from the pre-cycle counts and next-count arithmetic
    always_comb begin
        take_spec = 1'b0;
        take_norm = 1'b0;
        take_flr  = 1'b0;
        in_refuse = 1'b0;
        give_spec = 1'b0;
        give_norm = 1'b0;
        give_flr  = 1'b0;
        out_bad   = 1'b0;

        in_go  = in_ev & (in_state_q == StIdle);
        out_go = out_ev & (out_state_q == StIdle);

        if (in_go) begin
            if (bus.special && (spec_q != 3'd0)) begin
                take_spec = 1'b1;
            end else if (norm_q != 3'd0) begin
                take_norm = 1'b1;
            end else if (flr_q != 3'd0) begin
                take_flr = 1'b1;
            end else begin
                in_refuse = 1'b1;
            end
        end

        if (out_go) begin
            unique case (bus.out_zone)
                2'd0: begin
                    if (spec_q < CapSpec) give_spec = 1'b1;
                    else                  out_bad   = 1'b1;
                end
                2'd1: begin
                    if (norm_q < CapNorm) give_norm = 1'b1;
                    else                  out_bad   = 1'b1;
                end
                2'd2: begin
                    if (flr_q < CapFlr) give_flr = 1'b1;
                    else                out_bad  = 1'b1;
                end
                default: out_bad = 1'b1;
            endcase
        end

        in_accept  = in_go & ~in_refuse;
        out_accept = out_go & ~out_bad;

        // A take only happens on a nonzero count and a give only below
        // capacity, so a same-zone take+give nets to zero without wrapping.
        spec_d = spec_q - 3'(take_spec) + 3'(give_spec);
        norm_d = norm_q - 3'(take_norm) + 3'(give_norm);
        flr_d  = flr_q  - 3'(take_flr)  + 3'(give_flr);
    end

    // Free-spot counters, FULL from post-update counts, single REJECT pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_q   <= CapSpec;
            norm_q   <= CapNorm;
            flr_q    <= CapFlr;
            full_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            spec_q   <= spec_d;
            norm_q   <= norm_d;
            flr_q    <= flr_d;
            full_q   <= (spec_d == 3'd0) && (norm_d == 3'd0) && (flr_d == 3'd0);
            reject_q <= in_refuse | out_bad;
        end
    end

    // Entry gate FSM: opens on an accepted entry, closes after GATE_CYCLES
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q <= StIdle;
            in_timer_q <= '0;
            gate_in_q  <= 1'b0;
        end else begin
            unique case (in_state_q)
                StIdle: begin
                    if (in_accept) begin
                        in_state_q <= StOpen;
                        in_timer_q <= GateLast;
                        gate_in_q  <= 1'b1;
                    end
                end
                StOpen: begin
                    if (in_timer_q == '0) begin
                        in_state_q <= StIdle;
                        gate_in_q  <= 1'b0;
                    end else begin
                        in_timer_q <= in_timer_q - GateOne;
                    end
                end
                default: begin
                    in_state_q <= StIdle;
                    gate_in_q  <= 1'b0;
                end
            endcase
        end
    end

    // Exit gate FSM: opens on a valid exit, closes after GATE_CYCLES
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state_q <= StIdle;
            out_timer_q <= '0;
            gate_out_q  <= 1'b0;
        end else begin
            unique case (out_state_q)
                StIdle: begin
                    if (out_accept) begin
                        out_state_q <= StOpen;
                        out_timer_q <= GateLast;
                        gate_out_q  <= 1'b1;
                    end
                end
                StOpen: begin
                    if (out_timer_q == '0) begin
                        out_state_q <= StIdle;
                        gate_out_q  <= 1'b0;
                    end else begin
                        out_timer_q <= out_timer_q - GateOne;
                    end
                end
                default: begin
                    out_state_q <= StIdle;
                    gate_out_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.remain_flr_spec_0 = spec_q;
    assign bus.remain_flr_norm_0 = norm_q;
    assign bus.remain_flr_1      = flr_q;
    assign bus.gate_in_open      = gate_in_q;
    assign bus.gate_out_open     = gate_out_q;
    assign bus.full              = full_q;
    assign bus.reject            = reject_q;

endmodule

// File: tb/tb_parking_alloc_ctrl.sv
// Self-checking bench for parking_alloc_ctrl with a scoreboard of expected
// post-event states built from a reference allocation model.
module tb_parking_alloc_ctrl;

    localparam int CapS = 2;
    localparam int CapN = 3;
    localparam int CapF = 5;
    localparam int Gate = 8;

    typedef struct {
        logic [2:0] s;
        logic [2:0] n;
        logic [2:0] f;
        logic       rej;
        logic       full;
        logic       gin;
        logic       gout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    parking_alloc_ctrl_if bus ();

    parking_alloc_ctrl #(
        .GATE_CYCLES (Gate),
        .CAP_SPEC_0  (CapS),
        .CAP_NORM_0  (CapN),
        .CAP_FLR_1   (CapF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   m_s, m_n, m_f;
    bit   m_in_open, m_out_open;
    exp_t sb[$];

    task automatic do_reset();
        bus.btn_in   = 1'b0;
        bus.btn_out  = 1'b0;
        bus.special  = 1'b0;
        bus.out_zone = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        m_s = CapS; m_n = CapN; m_f = CapF;
        m_in_open = 1'b0; m_out_open = 1'b0;
        sb.delete();
    endtask

    // Drive one entry and/or exit press, predict, then compare at the 3rd edge.
    task automatic apply_event(input string name, input bit do_in, input bit spec,
                               input bit do_out, input logic [1:0] zone);
        exp_t e;
        exp_t got;
        bit   in_go, out_go, refused, bad;
        int   ds, dn, df, gs, gn, gf;
        ds = 0; dn = 0; df = 0; gs = 0; gn = 0; gf = 0;
        refused = 1'b0; bad = 1'b0;
        in_go  = do_in && !m_in_open;
        out_go = do_out && !m_out_open;
        if (in_go) begin
            if (spec && m_s > 0)  ds = 1;
            else if (m_n > 0)     dn = 1;
            else if (m_f > 0)     df = 1;
            else                  refused = 1'b1;
        end
        if (out_go) begin
            case (zone)
                2'd0: if (m_s < CapS) gs = 1; else bad = 1'b1;
                2'd1: if (m_n < CapN) gn = 1; else bad = 1'b1;
                2'd2: if (m_f < CapF) gf = 1; else bad = 1'b1;
                default: bad = 1'b1;
            endcase
        end
        e.s    = 3'(m_s - ds + gs);
        e.n    = 3'(m_n - dn + gn);
        e.f    = 3'(m_f - df + gf);
        e.rej  = refused | bad;
        e.full = (e.s == 0) && (e.n == 0) && (e.f == 0);
        e.gin  = m_in_open | (in_go & !refused);
        e.gout = m_out_open | (out_go & !bad);
        sb.push_back(e);

        @(negedge clk);
        bus.btn_in   = do_in;
        bus.special  = spec;
        bus.btn_out  = do_out;
        bus.out_zone = zone;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({bus.remain_flr_spec_0, bus.remain_flr_norm_0, bus.remain_flr_1} !==
            {3'(m_s), 3'(m_n), 3'(m_f)}) begin
            failures++;
            $display("FAIL %s early_update: got %0d/%0d/%0d before 3rd edge, required %0d/%0d/%0d",
                     name, bus.remain_flr_spec_0, bus.remain_flr_norm_0, bus.remain_flr_1,
                     m_s, m_n, m_f);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        got.s = bus.remain_flr_spec_0;
        got.n = bus.remain_flr_norm_0;
        got.f = bus.remain_flr_1;
        checks++;
        if ({got.s, got.n, got.f} !== {e.s, e.n, e.f}) begin
            failures++;
            $display("FAIL %s counts: got %0d/%0d/%0d required %0d/%0d/%0d",
                     name, got.s, got.n, got.f, e.s, e.n, e.f);
        end
        checks++;
        if (bus.reject !== e.rej) begin
            failures++;
            $display("FAIL %s reject: got %b required %b", name, bus.reject, e.rej);
        end
        checks++;
        if (bus.full !== e.full) begin
            failures++;
            $display("FAIL %s full: got %b required %b", name, bus.full, e.full);
        end
        checks++;
        if ({bus.gate_in_open, bus.gate_out_open} !== {e.gin, e.gout}) begin
            failures++;
            $display("FAIL %s gates: got in=%b out=%b required in=%b out=%b",
                     name, bus.gate_in_open, bus.gate_out_open, e.gin, e.gout);
        end
        m_s = e.s; m_n = e.n; m_f = e.f;
        m_in_open = e.gin; m_out_open = e.gout;

        @(negedge clk);
        bus.btn_in  = 1'b0;
        bus.btn_out = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.reject !== 1'b0) begin
            failures++;
            $display("FAIL %s reject_width: got %b required 0 one cycle later",
                     name, bus.reject);
        end
    endtask

    task automatic wait_gates_closed(input string name);
        int n;
        n = 0;
        while ((bus.gate_in_open || bus.gate_out_open) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.gate_in_open !== 1'b0 || bus.gate_out_open !== 1'b0) begin
            failures++;
            $display("FAIL %s gate_close_timeout: got in=%b out=%b required both 0",
                     name, bus.gate_in_open, bus.gate_out_open);
        end
        m_in_open = 1'b0;
        m_out_open = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.remain_flr_spec_0, bus.remain_flr_norm_0, bus.remain_flr_1} !==
            {3'(CapS), 3'(CapN), 3'(CapF)}) begin
            failures++;
            $display("FAIL reset_counts: got %0d/%0d/%0d required %0d/%0d/%0d",
                     bus.remain_flr_spec_0, bus.remain_flr_norm_0, bus.remain_flr_1,
                     CapS, CapN, CapF);
        end
        checks++;
        if ({bus.gate_in_open, bus.gate_out_open, bus.full, bus.reject} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_status: got gin/gout/full/rej=%b required 0000",
                     {bus.gate_in_open, bus.gate_out_open, bus.full, bus.reject});
        end
        do_reset();
    endtask

    task automatic test_single_entry();
        int highs;
        int rejs;
        do_reset();
        apply_event("single_entry", 1'b1, 1'b0, 1'b0, 2'd0);
        highs = 2;
        rejs = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.gate_in_open) highs++;
            if (bus.reject) rejs++;
        end
        checks++;
        if (highs !== Gate) begin
            failures++;
            $display("FAIL gate_in_duration: got %0d cycles required %0d", highs, Gate);
        end
        checks++;
        if (rejs !== 0) begin
            failures++;
            $display("FAIL single_entry_no_reject: got %0d pulses required 0", rejs);
        end
        m_in_open = 1'b0;
    endtask

    task automatic test_special_entries();
        do_reset();
        apply_event("special_1", 1'b1, 1'b1, 1'b0, 2'd0);
        wait_gates_closed("special_1");
        apply_event("special_2", 1'b1, 1'b1, 1'b0, 2'd0);
        wait_gates_closed("special_2");
        apply_event("special_3", 1'b1, 1'b1, 1'b0, 2'd0);
        apply_event("entry_while_open", 1'b1, 1'b0, 1'b0, 2'd0);
        wait_gates_closed("special_3");
    endtask

    task automatic test_fill();
        for (int i = 0; i < 7; i++) begin
            apply_event($sformatf("fill_%0d", i), 1'b1, 1'b0, 1'b0, 2'd0);
            wait_gates_closed("fill");
        end
        checks++;
        if (bus.full !== 1'b1) begin
            failures++;
            $display("FAIL full_flag: got %b required 1", bus.full);
        end
        apply_event("entry_when_full", 1'b1, 1'b1, 1'b0, 2'd0);
        wait_gates_closed("entry_when_full");
    endtask

    task automatic test_exit_invalid();
        do_reset();
        apply_event("exit_flr1_at_cap", 1'b0, 1'b0, 1'b1, 2'd2);
        apply_event("exit_zone3", 1'b0, 1'b0, 1'b1, 2'd3);
        apply_event("exit_spec_at_cap", 1'b0, 1'b0, 1'b1, 2'd0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        apply_event("fill_spec_a", 1'b1, 1'b1, 1'b0, 2'd0);
        wait_gates_closed("b2b");
        apply_event("fill_spec_b", 1'b1, 1'b1, 1'b0, 2'd0);
        wait_gates_closed("b2b");
        for (int i = 0; i < 8; i++) begin
            apply_event($sformatf("fill_norm_%0d", i), 1'b1, 1'b0, 1'b0, 2'd0);
            wait_gates_closed("b2b");
        end
        apply_event("simul_refuse_and_exit", 1'b1, 1'b0, 1'b1, 2'd1);
        wait_gates_closed("simul");
        apply_event("simul_same_zone", 1'b1, 1'b0, 1'b1, 2'd1);
        wait_gates_closed("simul_same");
        apply_event("simul_both_reject", 1'b1, 1'b0, 1'b1, 2'd3);
        wait_gates_closed("simul_both");
        apply_event("exit_then_entry_flr", 1'b1, 1'b1, 1'b1, 2'd2);
        wait_gates_closed("simul_flr");
    endtask

    task automatic test_reset_mid_open();
        do_reset();
        apply_event("mid_spec", 1'b1, 1'b1, 1'b0, 2'd0);
        wait_gates_closed("mid");
        for (int i = 0; i < 5; i++) begin
            apply_event($sformatf("mid_norm_%0d", i), 1'b1, 1'b0, 1'b0, 2'd0);
            wait_gates_closed("mid");
        end
        apply_event("mid_exit_a", 1'b0, 1'b0, 1'b1, 2'd1);
        wait_gates_closed("mid");
        apply_event("mid_exit_b", 1'b0, 1'b0, 1'b1, 2'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.btn_in = 1'b1;
        #1;
        checks++;
        if (bus.gate_out_open !== 1'b0 || bus.gate_in_open !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_open_gates: got in=%b out=%b required 0/0",
                     bus.gate_in_open, bus.gate_out_open);
        end
        checks++;
        if ({bus.remain_flr_spec_0, bus.remain_flr_norm_0, bus.remain_flr_1} !==
            {3'(CapS), 3'(CapN), 3'(CapF)}) begin
            failures++;
            $display("FAIL rst_mid_open_counts: got %0d/%0d/%0d required %0d/%0d/%0d",
                     bus.remain_flr_spec_0, bus.remain_flr_norm_0, bus.remain_flr_1,
                     CapS, CapN, CapF);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (bus.remain_flr_norm_0 !== 3'(CapN) || bus.gate_in_open !== 1'b0) begin
            failures++;
            $display("FAIL held_button_event: got norm=%0d gin=%b required %0d/0",
                     bus.remain_flr_norm_0, bus.gate_in_open, CapN);
        end
        m_s = CapS; m_n = CapN; m_f = CapF;
        m_in_open = 1'b0; m_out_open = 1'b0;
        @(negedge clk);
        bus.btn_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        apply_event("repress_after_reset", 1'b1, 1'b0, 1'b0, 2'd0);
        wait_gates_closed("repress");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.btn_in   = 1'b0;
        bus.btn_out  = 1'b0;
        bus.special  = 1'b0;
        bus.out_zone = 2'd0;
        test_reset();
        test_single_entry();
        test_special_entries();
        test_fill();
        test_exit_invalid();
        test_back_to_back();
        test_reset_mid_open();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parking_alloc_ctrl.md
PARKING_ALLOC_CTRL -- requirements
Module: parking_alloc_ctrl

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 8, giving the number of CLK cycles a gate stays open per accepted event.
REQ-002 The block SHALL have parameter CAP_SPEC_0, default 2, giving floor-0 special-spot capacity.
REQ-003 The block SHALL have parameter CAP_NORM_0, default 3, giving floor-0 normal-spot capacity.
REQ-004 The block SHALL have parameter CAP_FLR_1, default 5, giving floor-1 capacity; every capacity SHALL be at most 5, and their sum SHALL be at most 10.
REQ-005 CLK  input  1  the single system clock; all state SHALL be on its rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 BTN_IN  input  1  raw entry-request button, asynchronous to CLK, active-high.
REQ-008 SPECIAL  input  1  level, sampled with the entry event; 1 means special-permit car.
REQ-009 BTN_OUT  input  1  raw exit-request button, asynchronous, active-high.
REQ-010 OUT_ZONE  input  2  zone being vacated, sampled with the exit event: 0 = spec_0, 1 = norm_0, 2 = flr_1, 3 = invalid.
REQ-011 remain_flr_spec_0, remain_flr_norm_0, remain_flr_1  output  3 each  registered free-spot counts, feeding the 7-segment display stage.
REQ-012 GATE_IN_OPEN, GATE_OUT_OPEN  output  1 each  registered gate-open levels.
REQ-013 FULL  output  1  registered; high when all three counts are 0.
REQ-014 REJECT  output  1  one-cycle registered pulse for a refused entry or an invalid exit.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer followed by a rising-edge detector. The result is one event pulse per press, however long the button is held.
REQ-016 Entry event with the entry FSM in IDLE: the allocator SHALL evaluate the pre-cycle counts as follows.
- SPECIAL=1: decrement spec_0 if nonzero, else norm_0 if nonzero, else flr_1 if nonzero.
- SPECIAL=0: decrement norm_0 if nonzero, else flr_1 if nonzero; a non-special car SHALL never take spec_0.
REQ-017 Entry with no eligible nonzero zone SHALL be refused: REJECT pulses, counts are unchanged, and the gate stays closed.
REQ-018 Exit event with the exit FSM in IDLE: the selected zone SHALL increment.
- If OUT_ZONE=3, or the selected zone is already at capacity, the exit is invalid: REJECT pulses, counts are unchanged, and the gate stays closed.
REQ-019 Count update latency: the counts SHALL change on the 3rd CLK rising edge, counting the first edge that samples the button high as edge 1.
REQ-020 Entry FSM and exit FSM SHALL be independent, each with states IDLE and OPEN.
- IDLE->OPEN on an accepted event, at the same edge the count updates.
- OPEN->IDLE after exactly GATE_CYCLES cycles in OPEN.
- GATE_*_OPEN=1 exactly while in OPEN.
REQ-021 Events arriving while the matching FSM is OPEN SHALL be ignored: no count change, no REJECT.
REQ-022 Simultaneous accepted entry and exit in the same cycle SHALL both be applied.
- Allocation uses pre-cycle counts, so a spot freed in that cycle is not available to that entry.
- If entry and exit hit the same zone, that count is unchanged.
- Entry refused and exit invalid in the same cycle: REJECT is a single one-cycle pulse.
REQ-023 Counts SHALL never underflow below 0 or exceed their capacity.
REQ-024 FULL SHALL be registered from the post-update counts and change on the same edge as the counts.

Reset
REQ-025 RST high SHALL immediately and asynchronously set all of the following:
- remain_flr_spec_0=CAP_SPEC_0, remain_flr_norm_0=CAP_NORM_0, remain_flr_1=CAP_FLR_1.
- Both FSMs IDLE, gate outputs 0, FULL=0, REJECT=0.
- Synchronizer and edge-detector flops cleared.
REQ-026 A button held high across RST release SHALL NOT generate an event until it is released and pressed again.
REQ-027 RST asserted while a gate is OPEN SHALL close the gate at once and discard the remaining open time.

Verification
REQ-028 Reset, then a single normal entry -> at the 3rd edge, norm_0 goes 3->2; GATE_IN_OPEN is high for exactly 8 cycles; REJECT stays 0.
REQ-029 Three special entries from reset -> spec_0 2->1->0, then norm_0 3->2; a fourth normal entry before gate close is ignored.
REQ-030 Fill all 10 spots -> FULL=1 with counts 0/0/0; next entry -> single REJECT pulse, counts unchanged, gate closed.
REQ-031 From reset, exit with OUT_ZONE=2 (flr_1 at capacity 5) -> REJECT pulse, flr_1 stays 5; OUT_ZONE=3 -> REJECT.
REQ-032 State norm_0=0, flr_1=0, spec_0=0; normal entry and exit OUT_ZONE=1 in the same cycle -> entry REJECT, norm_0 becomes 1, GATE_OUT_OPEN=1.
REQ-033 RST pulsed mid-OPEN with counts 1/2/3 -> gates drop immediately; counts become 2/3/5; a held BTN_IN produces no event until released and pressed again.
